// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings, default latencies, FSM states.
// The optional divide-by-zero hold behaviour is selected with the MDU_DIV0_HOLD_EN macro.
package mdu_unit_pkg;

  localparam logic [2:0] MDU_MUL_SIGNED   = 3'b000;
  localparam logic [2:0] MDU_MUL_UNSIGNED = 3'b001;
  localparam logic [2:0] MDU_DIV_SIGNED   = 3'b010;
  localparam logic [2:0] MDU_DIV_UNSIGNED = 3'b011;
  localparam logic [2:0] MDU_MOVETO_HI    = 3'b100;
  localparam logic [2:0] MDU_MOVETO_LO    = 3'b101;
  localparam logic [2:0] MDU_RESERVED     = 3'b110;
  localparam logic [2:0] MDU_NONE         = 3'b111;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MDU_IDLE,
    MDU_RUN
  } mdu_state_e;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MDU_DIV_SIGNED) || (op == MDU_DIV_UNSIGNED);
  endfunction

endpackage

// File: rtl/mdu_unit_arith.sv
// Combinational 64-bit {hi,lo} result for mult/multu/div/divu, including divide-by-zero rules.
// Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without special casing.
module mdu_arith
  import mdu_unit_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o
);

  logic signed [63:0] sa, sb;
  logic [63:0] ua, ub;
  logic [31:0] mag_a, mag_b, sdiv_b, udiv_b;
  logic [31:0] uq, ur, sq, sr, q_u, r_u;
  logic        b_zero;

  always_comb begin
    sa     = {{32{a_i[31]}}, a_i};
    sb     = {{32{b_i[31]}}, b_i};
    ua     = {32'd0, a_i};
    ub     = {32'd0, b_i};
    b_zero = (b_i == 32'd0);

    // Divisors are forced to 1 on zero so no divider ever sees /0; the result is overridden below.
    udiv_b = b_zero ? 32'd1 : b_i;
    q_u    = a_i / udiv_b;
    r_u    = a_i % udiv_b;

    mag_a  = a_i[31] ? (~a_i + 32'd1) : a_i;
    mag_b  = b_i[31] ? (~b_i + 32'd1) : b_i;
    sdiv_b = b_zero ? 32'd1 : mag_b;
    uq     = mag_a / sdiv_b;
    ur     = mag_a % sdiv_b;
    sq     = (a_i[31] ^ b_i[31]) ? (~uq + 32'd1) : uq;
    sr     = a_i[31] ? (~ur + 32'd1) : ur;

    result_o = 64'd0;
    case (op_i)
      MDU_MUL_SIGNED:   result_o = sa * sb;
      MDU_MUL_UNSIGNED: result_o = ua * ub;
      MDU_DIV_SIGNED:   result_o = b_zero ? {a_i, 32'hFFFF_FFFF} : {sr, sq};
      MDU_DIV_UNSIGNED: result_o = b_zero ? {a_i, 32'hFFFF_FFFF} : {r_u, q_u};
      default:          result_o = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Define MDU_DIV0_HOLD_EN to keep HI/LO unchanged on divide by zero.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_mod,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        busy,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   pend_q, pend_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [63:0]   arith_res;
  logic          launch;

  mdu_arith u_arith (
    .op_i     (mdu_mod),
    .a_i      (in_a),
    .b_i      (in_b),
    .result_o (arith_res)
  );

  assign launch = start && !mdu_mod[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MDU_IDLE: begin
        if (launch) begin
          pend_d = arith_res;
`ifdef MDU_DIV0_HOLD_EN
          // HI/LO cannot change while running, so capturing them now is equivalent to holding.
          if (is_div_op(mdu_mod) && (in_b == 32'd0)) pend_d = {hi_q, lo_q};
`endif
          cnt_d   = is_div_op(mdu_mod) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d = MDU_RUN;
        end else if (!start && (mdu_mod == MDU_MOVETO_HI)) begin
          hi_d = in_a;
        end else if (!start && (mdu_mod == MDU_MOVETO_LO)) begin
          lo_d = in_a;
        end
      end
      MDU_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          state_d = MDU_IDLE;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  assign busy = (state_q == MDU_RUN);
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: directed vectors push expected {hi,lo,latency}; a monitor checks on busy falling.
// Divide-by-zero expectations follow MDU_DIV0_HOLD_EN.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_mod;
  logic [31:0] in_a, in_b;
  logic        busy;
  logic [31:0] hi_o, lo_o;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  int   busyCnt = 0;
  logic prevBusy = 1'b0;

  mdu_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mdu_mod (mdu_mod),
    .in_a    (in_a),
    .in_b    (in_b),
    .busy    (busy),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic checkOutput(input string name, input logic expBusy, input logic [31:0] expHi,
                             input logic [31:0] expLo);
    compareVal({name, "_busy"}, {31'd0, busy}, {31'd0, expBusy});
    compareVal({name, "_hi"}, hi_o, expHi);
    compareVal({name, "_lo"}, lo_o, expLo);
  endtask

  task automatic expectResult(input logic [31:0] hi, input logic [31:0] lo, input int cycles);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.cycles = cycles;
    expQ.push_back(e);
  endtask

  // Drives one cycle of inputs from posedge+1; returns at posedge+1 after the capturing edge.
  task automatic applyStimulus(input logic [2:0] mod, input logic [31:0] a, input logic [31:0] b,
                               input logic st);
    mdu_mod = mod;
    in_a    = a;
    in_b    = b;
    start   = st;
    @(posedge clk);
    #1;
    start   = 1'b0;
    mdu_mod = MDU_NONE;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle actual busy=1 required busy=0 within 100 cycles");
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prevBusy = 1'b0;
      busyCnt  = 0;
    end else begin
      if (busy) begin
        busyCnt++;
      end else if (prevBusy) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result actual hi=%h lo=%h required no completion", hi_o, lo_o);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          compareVal("result_hi", hi_o, e.hi);
          compareVal("result_lo", lo_o, e.lo);
          compareVal("busy_cycles", 32'(busyCnt), 32'(e.cycles));
        end
        busyCnt = 0;
      end
      prevBusy = busy;
    end
  end

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    mdu_mod = MDU_NONE;
    in_a    = '0;
    in_b    = '0;
    #3;
    checkOutput("in_reset", 1'b0, 32'h0, 32'h0);
    #9 reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("after_reset", 1'b0, 32'h0, 32'h0);

    expectResult(32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    applyStimulus(MDU_MUL_SIGNED, 32'hFFFF_FFFF, 32'd2, 1'b1);
    compareVal("mult_busy_rise", {31'd0, busy}, 32'd1);
    waitIdle();

    expectResult(32'h0000_0001, 32'hFFFF_FFFE, 5);
    applyStimulus(MDU_MUL_UNSIGNED, 32'hFFFF_FFFF, 32'd2, 1'b1);
    waitIdle();

    expectResult(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    applyStimulus(MDU_DIV_SIGNED, 32'hFFFF_FFF9, 32'd2, 1'b1);
    compareVal("div_busy_rise", {31'd0, busy}, 32'd1);
    waitIdle();

    expectResult(32'd1, 32'd3, 10);
    applyStimulus(MDU_DIV_UNSIGNED, 32'd7, 32'd2, 1'b1);
    waitIdle();

    expectResult(32'd1, 32'hFFFF_FFFD, 10);
    applyStimulus(MDU_DIV_SIGNED, 32'd7, 32'hFFFF_FFFE, 1'b1);
    waitIdle();

    expectResult(32'd0, 32'h8000_0000, 10);
    applyStimulus(MDU_DIV_SIGNED, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    waitIdle();

    expectResult(32'h4000_0000, 32'd0, 5);
    applyStimulus(MDU_MUL_SIGNED, 32'h8000_0000, 32'h8000_0000, 1'b1);
    waitIdle();

    // Second start lands on busy cycle 3 and must not disturb the running multiply.
    expectResult(32'd0, 32'd12, 5);
    applyStimulus(MDU_MUL_SIGNED, 32'd3, 32'd4, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(MDU_DIV_SIGNED, 32'd100, 32'd7, 1'b1);
    waitIdle();

    applyStimulus(MDU_MOVETO_HI, 32'h1234_5678, 32'd0, 1'b0);
    checkOutput("mthi", 1'b0, 32'h1234_5678, 32'd12);
    applyStimulus(MDU_MOVETO_LO, 32'h9ABC_DEF0, 32'd0, 1'b0);
    checkOutput("mtlo", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);

    applyStimulus(MDU_RESERVED, 32'd5, 32'd6, 1'b1);
    checkOutput("reserved_start", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    applyStimulus(MDU_NONE, 32'd5, 32'd6, 1'b1);
    checkOutput("none_start", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);

    applyStimulus(MDU_MOVETO_HI, 32'd1, 32'd0, 1'b0);
    applyStimulus(MDU_MOVETO_LO, 32'd2, 32'd0, 1'b0);
    checkOutput("preset", 1'b0, 32'd1, 32'd2);
`ifdef MDU_DIV0_HOLD_EN
    expectResult(32'd1, 32'd2, 10);
`else
    expectResult(32'h55, 32'hFFFF_FFFF, 10);
`endif
    applyStimulus(MDU_DIV_SIGNED, 32'h55, 32'd0, 1'b1);
    waitIdle();

    // Abort a divide on its fourth busy cycle; no completion is expected.
    applyStimulus(MDU_DIV_UNSIGNED, 32'd100, 32'd7, 1'b1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_div_reset", 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_abort", 1'b0, 32'h0, 32'h0);

    expectResult(32'd0, 32'd12, 5);
    applyStimulus(MDU_MUL_UNSIGNED, 32'd3, 32'd4, 1'b1);
    waitIdle();

    repeat (3) @(posedge clk);
    compareVal("pending_expectations", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage, driven by the decoder's mdu_start / mdu_mod outputs.
- Holds the architectural HI/LO registers.
- Serves mult/multu/div/divu/mthi/mtlo; mfhi/mflo read hi_o/lo_o directly.
- busy feeds the hazard unit, which stalls any md/hilo instruction in D while (busy | start).

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  one-cycle pulse: launch mult/multu/div/divu
- mdu_mod  input  3  operation select
- in_a  input  32  rs value (forwarded)
- in_b  input  32  rt value (forwarded)
- busy  output  1  operation in flight
- hi_o  output  32  HI register
- lo_o  output  32  LO register

Behaviour:
- mdu_mod encoding: 000 mul signed, 001 mul unsigned, 010 div signed, 011 div unsigned, 100 move-to-HI, 101 move-to-LO, 111 none; 110 reserved, treated as none.
- Reset (reset==0, async): busy=0, hi_o=0, lo_o=0, counter=0, pending results cleared. Reset mid-operation aborts the operation and HI/LO stay 0.
- States: IDLE, RUN.
- IDLE:
  - start=1 with mdu_mod in 000..011 on edge N: compute the 64-bit result from in_a/in_b into pending_hi/pending_lo, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN. busy=1 from edge N onward.
  - start=1 with any other mdu_mod: ignored.
- RUN: counter decrements each edge. On the edge where counter goes 1->0, hi_o/lo_o take the pending values, busy=0, return to IDLE.
- Timing: busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles. New HI/LO are visible the cycle busy falls.
- start while busy: ignored. Operands and operation are not re-latched, counter is not reloaded.
- mthi/mtlo (mdu_mod 100/101, start=0) in IDLE: hi_o<=in_a or lo_o<=in_a at the next edge; the other register is unchanged.
- mthi/mtlo while busy: ignored (the hazard unit guarantees this never happens).
- Multiply: signed = 32x32 two's-complement product; unsigned = zero-extended. {hi,lo} = 64-bit product.
- Divide: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend. Unsigned divide treats both operands as unsigned.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero: see Optional Feature.
- Simultaneous start and end-of-operation cannot occur; start is ignored while busy is high.

Optional Feature:
- Macro: MDU_DIV0_HOLD_EN.
- Defined: div/divu with in_b==0 still asserts busy for DIV_CYCLES, but HI and LO keep their prior values.
- Undefined: div by zero writes lo=0xFFFFFFFF and hi=in_a. No X values in either case.

Decomposition:
- Add the mdu_mod encodings to the shared define file as `mdu_mul_signed … `mdu_moveto_LO and `mdu_none (3'b111).
- Add the default cycle counts to the same file.
- One natural sub-module: mdu_arith, purely combinational. It takes op, a, b and produces the 64-bit {hi,lo} result, including the signed/unsigned and div-by-zero rules.
- mdu_unit holds the FSM, counter, pending registers and HI/LO.

Test Plan:
- Reset low mid-div (cycle 4 of 10) -> busy=0, hi_o=lo_o=0 asynchronously; after release, state is IDLE.
- mult, a=0xFFFFFFFF, b=2, start pulse -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Same operands with multu -> hi=0x00000001, lo=0xFFFFFFFE.
- div, a=-7 (0xFFFFFFF9), b=2 -> busy high 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu, a=7, b=2 -> lo=3, hi=1.
- start re-pulsed at busy cycle 3 with different operands -> ignored; busy still falls after 5 cycles total; result is from the first operands.
- mthi a=0x12345678, then mtlo a=0x9ABCDEF0 on consecutive cycles -> hi_o/lo_o update one edge after each; busy stays 0.
- div by zero, a=0x55, b=0, with HI/LO preset to 1/2 -> with MDU_DIV0_HOLD_EN: hi=1, lo=2 after 10 cycles; without: hi=0x55, lo=0xFFFFFFFF.
